apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one APB master/slave datapath between NUM_REQ requesters.
- Accepts one read/write request at a time and drives the datapath command (add_i encoding: 2'b11 write, 2'b01 read, 2'b00 idle) and write data.
- Waits for the datapath ready, captures read data one cycle after ready, and returns completion or timeout status to the winning requester.
- Sits between client logic and the APB master/slave top, connecting directly to its add_i, external_wdata_i, ready_o and rdata_o.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 32, data width.
- TIMEOUT_CYC, 16, maximum ACCESS cycles waiting for ready; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- preset_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request; held high until granted.
- req_write_i  in  NUM_REQ  per-requester direction, 1=write, 0=read.
- req_wdata_i  in  NUM_REQ*DATA_W  per-requester write data; slice i belongs to requester i.
- req_grant_o  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- req_done_o  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished.
- req_err_o  out  1  high with req_done_o when the transaction timed out.
- req_rdata_o  out  DATA_W  read data, valid in the req_done_o cycle of a read.
- add_o  out  2  command to the datapath add_i.
- wdata_o  out  DATA_W  write data to the datapath external_wdata_i.
- ready_i  in  1  datapath ready_o.
- rdata_i  in  DATA_W  datapath rdata_o.
- busy_o  out  1  high while the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (preset_n=0 at a posedge) forces:
  - state=IDLE, add_o=2'b00, wdata_o=0, req_rdata_o=0;
  - req_grant_o=0, req_done_o=0, req_err_o=0, busy_o=0, timeout counter=0;
  - rr pointer=NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-transaction aborts it silently: no done pulse, add_o returns to 00 on the next cycle.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE:
  - If any req_valid_i is high at the posedge, select winner w as the first set bit searching from rr+1 upward, wrapping modulo NUM_REQ.
  - At that edge: latch dir=req_write_i[w] and data=req_wdata_i slice w.
  - Next cycle: req_grant_o[w]=1 for exactly one cycle, add_o=dir?2'b11:2'b01, wdata_o=data, state=ACCESS, counter=0.
  - If no request: remain IDLE, add_o=00.
- ACCESS:
  - add_o and wdata_o are held stable.
  - If ready_i=1 at a posedge: go to CAPTURE, add_o=00.
  - Else counter+1. If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: go to CAPTURE with err flag set, add_o=00.
- CAPTURE:
  - Lasts one cycle.
  - At its closing posedge:
    - req_rdata_o<=rdata_i for a read without error; otherwise req_rdata_o holds its value.
    - req_done_o[w]<=1 and req_err_o<=err for one cycle; rr<=w; state=IDLE.
- Arbitration is not evaluated in CAPTURE. The earliest next grant appears one cycle after the done pulse.
- Minimum transaction with ready returned immediately: grant cycle (ACCESS) -> CAPTURE -> done in the IDLE cycle, i.e. 3 cycles from grant to done.
- Requester rules:
  - Deassert req_valid_i in the cycle after req_grant_o.
  - Do not reassert until after req_done_o.
  - A valid still high in the grant cycle is treated as a new request at the next IDLE.
- Simultaneous requests resolve by rr order only. A requester whose valid drops before grant is never granted.
- busy_o=1 in ACCESS and CAPTURE.
- ready_i is ignored in IDLE and CAPTURE.

Test Plan:
- Reset then req0 write 0x1234ABCD, ready_i high 2 cycles after grant:
  - add_o=11 and wdata_o=0x1234ABCD from the grant cycle until ready;
  - add_o=00 after ready; req_done_o[0] 2 cycles later; req_err_o=0.
- req0 read, ready_i pulse, rdata_i=0x1234ABCD in the cycle after ready -> req_rdata_o=0x1234ABCD with req_done_o[0], add_o=01 during ACCESS.
- req0 and req1 assert in the same cycle from reset -> req0 granted first, req1 granted after req0 done.
  - Repeating with both asserting again -> req1 wins next (alternation over 4 rounds).
- TIMEOUT_CYC=16, ready_i held 0 -> add_o returns to 00 after 16 ACCESS cycles; req_done_o with req_err_o=1; req_rdata_o unchanged.
- preset_n=0 for one cycle during ACCESS -> next cycle add_o=00, busy_o=0, no done pulse, and req0 has top priority again.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter and sequencer that shares one APB master/slave datapath
// between NUM_REQ requesters. It accepts one request at a time, drives the
// datapath command and write data, and waits for ready. Read data is captured
// one cycle after ready. Completion, or a timeout error, is returned to the
// requester that won arbitration.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   DATA_W       data width
//   TIMEOUT_CYC  maximum ACCESS cycles spent waiting for ready (0 = no limit)
//
// Ports
//   pclk, preset_n  clock (rising edge) and synchronous active-low reset
//   req_valid_i     per-requester request, held high until granted
//   req_write_i     per-requester direction (1 = write, 0 = read)
//   req_wdata_i     per-requester write data, slice i belongs to requester i
//   req_grant_o     one-hot, single-cycle pulse: request accepted
//   req_done_o      one-hot, single-cycle pulse: transaction finished
//   req_err_o       high together with req_done_o when the transaction timed out
//   req_rdata_o     read data, valid in the req_done_o cycle of a read
//   add_o           datapath command: 2'b11 write, 2'b01 read, 2'b00 idle
//   wdata_o         datapath write data
//   ready_i         datapath ready
//   rdata_i         datapath read data
//   busy_o          high while a transaction is in progress
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_grant_o,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic                      req_err_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic [1:0]                add_o,
  output logic [DATA_W-1:0]         wdata_o,
  input  logic                      ready_i,
  input  logic [DATA_W-1:0]         rdata_i,
  output logic                      busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           add_q, add_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 dir_q, dir_d;
  logic                 tout_q, tout_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;

  // Round-robin search: the first valid requester strictly after the last
  // winner, wrapping modulo NUM_REQ. The found flag keeps the nearest one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IDX_W'((32'(rr_q) + i) % NUM_REQ);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    tout_d  = tout_q;

    case (state_q)
      ST_IDLE: begin
        add_d = CMD_IDLE;
        if (win_found) begin
          owner_d          = win_idx;
          dir_d            = req_write_i[win_idx];
          wdata_d          = req_wdata_i[32'(win_idx) * DATA_W +: DATA_W];
          add_d            = req_write_i[win_idx] ? CMD_WRITE : CMD_READ;
          grant_d[win_idx] = 1'b1;
          cnt_d            = '0;
          tout_d           = 1'b0;
          state_d          = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Ready wins over a timeout landing on the same edge.
        if (ready_i) begin
          add_d   = CMD_IDLE;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
            add_d   = CMD_IDLE;
            tout_d  = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        // The datapath presents read data one cycle after ready.
        if (!dir_q && !tout_q) begin
          rdata_d = rdata_i;
        end
        done_d[owner_q] = 1'b1;
        err_d           = tout_q;
        rr_d            = owner_q;
        state_d         = ST_IDLE;
      end

      default: begin
        add_d   = CMD_IDLE;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= ST_IDLE;
      add_q   <= CMD_IDLE;
      wdata_q <= '0;
      rdata_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      dir_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      tout_q  <= tout_d;
    end
  end

  assign req_grant_o = grant_q;
  assign req_done_o  = done_q;
  assign req_err_o   = err_q;
  assign req_rdata_o = rdata_q;
  assign add_o       = add_q;
  assign wdata_o     = wdata_q;
  assign busy_o      = busy_q;

endmodule
